// File: rtl/bsg_manycore_vcache_dma_to_wormhole_pkg.sv
// Shared types for the vcache DMA to wormhole bridge: wormhole opcodes,
// FSM state encodings and the request-to-opcode mapping.
package bsg_manycore_vcache_dma_to_wormhole_pkg;

    typedef enum logic [1:0] {
        e_cache_wh_read             = 2'd0,
        e_cache_wh_write_non_masked = 2'd1,
        e_cache_wh_write_masked     = 2'd2
    } bsg_cache_wh_opcode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_ADDR,
        TX_MASK,
        TX_DATA
    } tx_state_e;

    typedef enum logic {
        RX_HDR,
        RX_DATA
    } rx_state_e;

    // A full mask lets the memory side skip the mask flit entirely.
    function automatic bsg_cache_wh_opcode_e wh_opcode_f(input logic write_not_read,
                                                         input logic mask_full);
        if (!write_not_read)
            return e_cache_wh_read;
        else if (mask_full)
            return e_cache_wh_write_non_masked;
        else
            return e_cache_wh_write_masked;
    endfunction

endpackage

// File: rtl/bsg_manycore_vcache_dma_to_wormhole_if.sv
// Ready/valid wormhole link pair: tx_* leaves the bridge, rx_* enters it.
interface bsg_manycore_vcache_dma_to_wormhole_if #(
    parameter int flit_width_p = 32
);
    logic                    tx_v;
    logic [flit_width_p-1:0] tx_data;
    logic                    tx_ready_and_rev;
    logic                    rx_v;
    logic [flit_width_p-1:0] rx_data;
    logic                    rx_ready_and_rev;

    modport master (
        output tx_v, tx_data, rx_ready_and_rev,
        input  tx_ready_and_rev, rx_v, rx_data
    );

    modport slave (
        input  tx_v, tx_data, rx_ready_and_rev,
        output tx_ready_and_rev, rx_v, rx_data
    );
endinterface

// File: rtl/bsg_manycore_vcache_dma_to_wormhole_counter.sv
// Clear/up beat counter used by both the TX and RX flit sequencers.
module bsg_manycore_vcache_dma_to_wormhole_counter #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);
    logic [width_p-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i)
            count_d = count_q + width_p'(1);
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/bsg_manycore_vcache_dma_to_wormhole.sv
// Bridges one vcache DMA port onto a cache wormhole link: TX serializes requests
// and evictions into flits, RX streams fill responses back to the cache.
module bsg_manycore_vcache_dma_to_wormhole
    import bsg_manycore_vcache_dma_to_wormhole_pkg::*;
#(
    parameter int addr_width_p          = 32,
    parameter int block_size_in_words_p = 4,
    parameter int dma_data_width_p      = 32,
    parameter int wh_flit_width_p       = 32,
    parameter int wh_cid_width_p        = 2,
    parameter int wh_len_width_p        = 4,
    parameter int wh_cord_width_p       = 5
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [addr_width_p+block_size_in_words_p:0] dma_pkt_i,
    input  logic                                      dma_pkt_v_i,
    output logic                                      dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0]               dma_data_o,
    output logic                                      dma_data_v_o,
    input  logic                                      dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0]               dma_data_i,
    input  logic                                      dma_data_v_i,
    output logic                                      dma_data_yumi_o,
    input  logic [wh_cord_width_p-1:0]                my_wh_cord_i,
    input  logic [wh_cid_width_p-1:0]                 my_wh_cid_i,
    input  logic [wh_cord_width_p-1:0]                dest_wh_cord_i,
    bsg_manycore_vcache_dma_to_wormhole_if.master     wh_link
);
    localparam int data_len_lp      = block_size_in_words_p*32/dma_data_width_p;
    localparam int tx_cnt_width_lp  = (data_len_lp > 1) ? $clog2(data_len_lp) : 1;
    localparam int hdr_used_lp      = 2*wh_cord_width_p + 2*wh_cid_width_p + wh_len_width_p
                                      + $bits(bsg_cache_wh_opcode_e);

    typedef struct packed {
        logic [wh_flit_width_p-hdr_used_lp-1:0] unused;
        bsg_cache_wh_opcode_e                   opcode;
        logic [wh_cid_width_p-1:0]              src_cid;
        logic [wh_cord_width_p-1:0]             src_cord;
        logic [wh_cid_width_p-1:0]              cid;
        logic [wh_len_width_p-1:0]              len;
        logic [wh_cord_width_p-1:0]             cord;
    } wh_header_s;

    typedef struct packed {
        logic                             write_not_read;
        logic [addr_width_p-1:0]          addr;
        logic [block_size_in_words_p-1:0] mask;
    } dma_pkt_s;

    if (dma_data_width_p != wh_flit_width_p) begin : g_width_chk
        $error("dma_data_width_p must equal wh_flit_width_p");
    end
    if (data_len_lp < 1) begin : g_len_chk
        $error("data_len_lp must be at least 1");
    end

    tx_state_e                   tx_state_d, tx_state_q;
    rx_state_e                   rx_state_d, rx_state_q;
    dma_pkt_s                    pkt_d, pkt_q;
    logic [wh_len_width_p-1:0]   rx_len_d, rx_len_q;
    bsg_cache_wh_opcode_e        tx_op;
    wh_header_s                  tx_hdr;
    logic                        tx_v, pkt_yumi, evict_yumi, tx_cnt_up, tx_cnt_clear;
    logic [wh_flit_width_p-1:0]  tx_data;
    logic [tx_cnt_width_lp-1:0]  tx_cnt;
    logic                        rx_ready, fill_v, rx_cnt_up, rx_cnt_clear;
    logic [wh_len_width_p-1:0]   rx_cnt, rx_len_in;

    assign tx_op = wh_opcode_f(pkt_q.write_not_read, &pkt_q.mask);

    always_comb begin
        tx_hdr          = '0;
        tx_hdr.cord     = dest_wh_cord_i;
        tx_hdr.src_cord = my_wh_cord_i;
        tx_hdr.src_cid  = my_wh_cid_i;
        tx_hdr.opcode   = tx_op;
        case (tx_op)
            e_cache_wh_read:             tx_hdr.len = wh_len_width_p'(1);
            e_cache_wh_write_non_masked: tx_hdr.len = wh_len_width_p'(1 + data_len_lp);
            default:                     tx_hdr.len = wh_len_width_p'(2 + data_len_lp);
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        tx_state_d   = tx_state_q;
        pkt_d        = pkt_q;
        tx_v         = 1'b0;
        tx_data      = '0;
        pkt_yumi     = 1'b0;
        evict_yumi   = 1'b0;
        tx_cnt_up    = 1'b0;
        tx_cnt_clear = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (dma_pkt_v_i) begin
                    pkt_yumi   = 1'b1;
                    pkt_d      = dma_pkt_i;
                    tx_state_d = TX_HDR;
                end
            end
            TX_HDR: begin
                tx_v    = 1'b1;
                tx_data = tx_hdr;
                if (wh_link.tx_ready_and_rev)
                    tx_state_d = TX_ADDR;
            end
            TX_ADDR: begin
                tx_v    = 1'b1;
                tx_data = wh_flit_width_p'(pkt_q.addr);
                if (wh_link.tx_ready_and_rev) begin
                    if (tx_op == e_cache_wh_read)
                        tx_state_d = TX_IDLE;
                    else if (tx_op == e_cache_wh_write_masked)
                        tx_state_d = TX_MASK;
                    else
                        tx_state_d = TX_DATA;
                end
            end
            TX_MASK: begin
                tx_v    = 1'b1;
                tx_data = wh_flit_width_p'(pkt_q.mask);
                if (wh_link.tx_ready_and_rev)
                    tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                // Evict data is cut through to the link with no staging register.
                tx_v       = dma_data_v_i;
                tx_data    = dma_data_i;
                evict_yumi = dma_data_v_i & wh_link.tx_ready_and_rev;
                tx_cnt_up  = evict_yumi;
                if (evict_yumi && (tx_cnt == tx_cnt_width_lp'(data_len_lp - 1))) begin
                    tx_cnt_clear = 1'b1;
                    tx_state_d   = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Len field position follows the header layout: cord occupies the low bits.
    assign rx_len_in = wh_link.rx_data[wh_cord_width_p +: wh_len_width_p];

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_len_d     = rx_len_q;
        rx_ready     = 1'b0;
        fill_v       = 1'b0;
        rx_cnt_up    = 1'b0;
        rx_cnt_clear = 1'b0;
        case (rx_state_q)
            RX_HDR: begin
                rx_ready = 1'b1;
                if (wh_link.rx_v && (rx_len_in != '0)) begin
                    rx_len_d   = rx_len_in;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                fill_v    = wh_link.rx_v;
                rx_ready  = dma_data_ready_and_i;
                rx_cnt_up = wh_link.rx_v & dma_data_ready_and_i;
                if (rx_cnt_up && (rx_cnt == rx_len_q - wh_len_width_p'(1))) begin
                    rx_cnt_clear = 1'b1;
                    rx_state_d   = RX_HDR;
                end
            end
            default: rx_state_d = RX_HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_HDR;
            pkt_q      <= '0;
            rx_len_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            pkt_q      <= pkt_d;
            rx_len_q   <= rx_len_d;
        end
    end

    bsg_manycore_vcache_dma_to_wormhole_counter #(.width_p(tx_cnt_width_lp)) tx_counter (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(tx_cnt_clear), .up_i(tx_cnt_up), .count_o(tx_cnt)
    );

    bsg_manycore_vcache_dma_to_wormhole_counter #(.width_p(wh_len_width_p)) rx_counter (
        .clk_i(clk_i), .reset_i(reset_i), .clear_i(rx_cnt_clear), .up_i(rx_cnt_up), .count_o(rx_cnt)
    );

    // Outputs are forced quiet while reset is held so the link never sees a stray flit.
    assign dma_pkt_yumi_o           = pkt_yumi & ~reset_i;
    assign dma_data_yumi_o          = evict_yumi & ~reset_i;
    assign dma_data_v_o             = fill_v & ~reset_i;
    assign dma_data_o               = wh_link.rx_data;
    assign wh_link.tx_v             = tx_v & ~reset_i;
    assign wh_link.tx_data          = reset_i ? '0 : tx_data;
    assign wh_link.rx_ready_and_rev = rx_ready & ~reset_i;

    assert property (@(posedge clk_i) disable iff (reset_i)
        (rx_state_q == RX_HDR && wh_link.rx_v) |-> (rx_len_in != '0));

endmodule
